// File: rtl/riscv_data_mw.sv
// riscv_data_mw: memory/writeback stage. Registers the execute-stage result,
// issues one data-memory access per load/store over a valid/ready request
// channel, and drives the register-file write and MW->DX forwarding flags.
module riscv_data_mw #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dx_inst,
  input  logic [31:0] dx_pc,
  input  logic [31:0] dx_ALU_out,
  input  logic [31:0] dx_rf_out_B_forwarded,
  output logic        mw_stall,
  output logic [31:0] mw_inst,
  output logic [31:0] mw_pc,
  output logic [31:0] mw_ALU_out,
  output logic [31:0] mw_WBMux_out,
  output logic        hazard_mw_dx_ra,
  output logic        hazard_mw_dx_rb,
  output logic [31:0] rf_write_data,
  output logic [4:0]  rf_rd,
  output logic        rf_regwe,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_wdata,
  output logic [3:0]  dmem_req_wmask,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_data
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic {S_IDLE, S_WAIT_RESP} state_t;
  state_t state, state_nxt;

  logic [31:0] mw_store_data;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [1:0]  byte_off;
  logic        is_load, is_store, is_mem, is_jump, regwe_dec, rd_nz;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  st_mask;
  logic [31:0] st_data;

  // Stage registers: capture the execute-stage values unless the stage is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mw_inst       <= '0;
      mw_pc         <= RESET_PC;
      mw_ALU_out    <= '0;
      mw_store_data <= '0;
    end else if (!mw_stall) begin
      mw_inst       <= dx_inst;
      mw_pc         <= dx_pc;
      mw_ALU_out    <= dx_ALU_out;
      mw_store_data <= dx_rf_out_B_forwarded;
    end
  end

  // Instruction field decode and register-write classification.
  always_comb begin
    opcode    = mw_inst[6:0];
    funct3    = mw_inst[14:12];
    rd        = mw_inst[11:7];
    byte_off  = mw_ALU_out[1:0];
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_mem    = is_load | is_store;
    is_jump   = (opcode == OPC_JAL) | (opcode == OPC_JALR);
    rd_nz     = (rd != 5'd0);
    regwe_dec = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: regwe_dec = 1'b1;
      default:                      regwe_dec = 1'b0;
    endcase
  end

  // Load extraction from the aligned response word; no misalignment trap.
  always_comb begin
    ld_byte = dmem_resp_data[{byte_off, 3'b000} +: 8];
    ld_half = byte_off[1] ? dmem_resp_data[31:16] : dmem_resp_data[15:0];
    ld_data = dmem_resp_data;
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = dmem_resp_data;
    endcase
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    st_mask = '0;
    st_data = mw_store_data;
    case (funct3)
      3'b000: begin
        st_mask = 4'b0001 << byte_off;
        st_data = {4{mw_store_data[7:0]}};
      end
      3'b001: begin
        st_mask = 4'b0011 << {byte_off[1], 1'b0};
        st_data = {2{mw_store_data[15:0]}};
      end
      3'b010:  st_mask = 4'b1111;
      default: st_mask = '0;
    endcase
  end

  // Writeback source select.
  always_comb begin
    if (is_load)      mw_WBMux_out = ld_data;
    else if (is_jump) mw_WBMux_out = mw_pc + 32'd4;
    else              mw_WBMux_out = mw_ALU_out;
  end

  // Memory access state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Request issue, response wait and upstream stall generation.
  always_comb begin
    state_nxt      = state;
    dmem_req_valid = 1'b0;
    mw_stall       = 1'b0;
    case (state)
      S_IDLE: begin
        dmem_req_valid = is_mem;
        if (is_mem) begin
          if (!dmem_req_ready) begin
            mw_stall = 1'b1;
          end else if (is_load) begin
            mw_stall  = 1'b1;
            state_nxt = S_WAIT_RESP;
          end
        end
      end
      S_WAIT_RESP: begin
        mw_stall = !dmem_resp_valid;
        if (dmem_resp_valid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign dmem_req_we     = is_store;
  assign dmem_req_addr   = {mw_ALU_out[31:2], 2'b00};
  assign dmem_req_wdata  = st_data;
  assign dmem_req_wmask  = is_store ? st_mask : 4'b0000;

  assign rf_write_data   = mw_WBMux_out;
  assign rf_rd           = rd;
  assign rf_regwe        = regwe_dec & rd_nz & ~mw_stall;

  assign hazard_mw_dx_ra = regwe_dec & rd_nz & (rd == dx_inst[19:15]);
  assign hazard_mw_dx_rb = regwe_dec & rd_nz & (rd == dx_inst[24:20]);

endmodule

// File: tb/tb_riscv_data_mw.sv
// tb_riscv_data_mw: scoreboard bench for the memory/writeback stage.
module tb_riscv_data_mw;

  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JAL    = 7'h6f;
  localparam logic [6:0] JALR   = 7'h67;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dx_inst, dx_pc, dx_ALU_out, dx_rf_out_B_forwarded;
  logic        mw_stall;
  logic [31:0] mw_inst, mw_pc, mw_ALU_out, mw_WBMux_out;
  logic        hazard_mw_dx_ra, hazard_mw_dx_rb;
  logic [31:0] rf_write_data;
  logic [4:0]  rf_rd;
  logic        rf_regwe;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_wmask;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;

  always #5 clk = ~clk;

  riscv_data_mw #(.RESET_PC(32'h0000_2000)) dut (
    .clk(clk), .rst(rst),
    .dx_inst(dx_inst), .dx_pc(dx_pc), .dx_ALU_out(dx_ALU_out),
    .dx_rf_out_B_forwarded(dx_rf_out_B_forwarded),
    .mw_stall(mw_stall), .mw_inst(mw_inst), .mw_pc(mw_pc),
    .mw_ALU_out(mw_ALU_out), .mw_WBMux_out(mw_WBMux_out),
    .hazard_mw_dx_ra(hazard_mw_dx_ra), .hazard_mw_dx_rb(hazard_mw_dx_rb),
    .rf_write_data(rf_write_data), .rf_rd(rf_rd), .rf_regwe(rf_regwe),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_wmask(dmem_req_wmask),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data)
  );

  typedef struct packed {logic [31:0] inst, pc, alu, b;} mw_t;
  typedef struct packed {logic [31:0] addr, wdata; logic we; logic [3:0] mask; logic cmp_wdata;} mreq_t;
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_t;

  mw_t   cur;
  mreq_t exp_mem[$];
  wb_t   exp_wb[$];

  int          n_vec = 0, n_err = 0;
  bit          rnd_mode = 1'b0, force_en = 1'b0;
  logic [31:0] force_data = '0;
  int          ready_hold = 0, resp_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, f3, rd, op};
  endfunction

  // Backing memory contents as a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit writes_rd(input logic [6:0] op);
    return (op == LOAD) || (op == OP) || (op == OP_IMM) || (op == LUI) ||
           (op == AUIPC) || (op == JAL) || (op == JALR);
  endfunction

  function automatic logic [31:0] ld_ext(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] by, hw;
    by = (w >> (8 * a)) & 32'hFF;
    hw = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (by >= 32'd128)   ? by - 32'd256   : by;
      3'd1:    return (hw >= 32'd32768) ? hw - 32'd65536 : hw;
      3'd4:    return by;
      3'd5:    return hw;
      default: return w;
    endcase
  endfunction

  // Reference model: expected memory request and register write for one instruction.
  task automatic model_enter(input mw_t x);
    logic [6:0] op; logic [2:0] f3; logic [4:0] rd; logic [1:0] a;
    logic [31:0] w, val, waddr;
    mreq_t m; wb_t r;
    op = x.inst[6:0]; f3 = x.inst[14:12]; rd = x.inst[11:7]; a = x.alu[1:0];
    waddr = x.alu & 32'hFFFF_FFFC;
    w = force_en ? force_data : mem_word(waddr);
    if (op == LOAD || op == STORE) begin
      m = '0;
      m.addr = waddr;
      m.we = (op == STORE);
      if (m.we) begin
        case (f3)
          3'd0: begin m.mask = 4'(1 << a);          m.wdata = (x.b & 32'hFF)   * 32'h0101_0101; end
          3'd1: begin m.mask = 4'(3 << (2 * a[1])); m.wdata = (x.b & 32'hFFFF) * 32'h0001_0001; end
          3'd2: begin m.mask = 4'hF;                m.wdata = x.b; end
          default: m.mask = 4'h0;
        endcase
      end
      m.cmp_wdata = (m.mask != 4'h0);
      exp_mem.push_back(m);
    end
    if (writes_rd(op) && rd != 5'd0) begin
      if (op == LOAD)                   val = ld_ext(f3, a, w);
      else if (op == JAL || op == JALR) val = x.pc + 32'd4;
      else                              val = x.alu;
      r.rd = rd; r.data = val;
      exp_wb.push_back(r);
    end
  endtask

  // Present one instruction; returns once the stage has taken it. stalls counts
  // the stall cycles of the instruction that was in the stage before it.
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] b, output int stalls);
    mw_t nx;
    dx_inst = ins; dx_pc = pc; dx_ALU_out = alu; dx_rf_out_B_forwarded = b;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!mw_stall) break;
      stalls++;
      if (stalls > 100) begin
        n_vec++; n_err++;
        $display("FAIL stall_timeout: mw_stall=%0b after %0d cycles, required 0", mw_stall, stalls);
        summary();
        $finish;
      end
    end
    @(posedge clk); #1;
    nx = '{ins, pc, alu, b};
    cur = nx;
    model_enter(nx);
  endtask

  // Memory responder: drives ready and returns load data after a latency.
  initial begin : responder
    bit pending; int cnt, wcnt; logic [31:0] paddr;
    pending = 1'b0; cnt = 0; wcnt = 0; paddr = '0;
    dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_data = '0;
    forever begin
      @(negedge clk);
      if (pending && dmem_resp_valid) pending = 1'b0;
      if (rst && dmem_req_valid && dmem_req_ready && !dmem_req_we) begin
        pending = 1'b1;
        paddr = dmem_req_addr;
        cnt = rnd_mode ? int'($urandom_range(0, 3)) : resp_lat;
      end
      wcnt = (dmem_req_valid && !dmem_req_ready) ? wcnt + 1 : 0;
      @(posedge clk); #1;
      dmem_req_ready = rnd_mode ? ($urandom_range(0, 9) < 7) : (wcnt >= ready_hold);
      dmem_resp_valid = 1'b0;
      dmem_resp_data = $urandom;
      if (pending) begin
        if (cnt == 0) begin
          dmem_resp_valid = 1'b1;
          dmem_resp_data = force_en ? force_data : mem_word(paddr);
        end else begin
          cnt--;
        end
      end else if (rnd_mode && $urandom_range(0, 7) == 0) begin
        dmem_resp_valid = 1'b1;
      end
    end
  end

  // Monitor: compares stage registers, hazard flags, accepted requests and register writes.
  initial begin : monitor
    mreq_t m; wb_t r; logic hz_a, hz_b;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rst_regwe", 32'(rf_regwe), 32'd0);
      end else begin
        chk("mw_inst", mw_inst, cur.inst);
        chk("mw_pc", mw_pc, cur.pc);
        chk("mw_ALU_out", mw_ALU_out, cur.alu);
        hz_a = writes_rd(cur.inst[6:0]) && cur.inst[11:7] != 5'd0 && cur.inst[11:7] == dx_inst[19:15];
        hz_b = writes_rd(cur.inst[6:0]) && cur.inst[11:7] != 5'd0 && cur.inst[11:7] == dx_inst[24:20];
        chk("hazard_ra", 32'(hazard_mw_dx_ra), 32'(hz_a));
        chk("hazard_rb", 32'(hazard_mw_dx_rb), 32'(hz_b));
        if (dmem_req_valid && dmem_req_ready) begin
          if (exp_mem.size() == 0) chk("req_unexpected", 32'(dmem_req_valid), 32'd0);
          else begin
            m = exp_mem.pop_front();
            chk("req_addr", dmem_req_addr, m.addr);
            chk("req_we", 32'(dmem_req_we), 32'(m.we));
            chk("req_wmask", 32'(dmem_req_wmask), 32'(m.mask));
            if (m.cmp_wdata) chk("req_wdata", dmem_req_wdata, m.wdata);
          end
        end
        if (rf_regwe) begin
          if (exp_wb.size() == 0) chk("regwe_unexpected", 32'(rf_regwe), 32'd0);
          else begin
            r = exp_wb.pop_front();
            chk("rf_rd", 32'(rf_rd), 32'(r.rd));
            chk("rf_write_data", rf_write_data, r.data);
            chk("mw_WBMux_out", mw_WBMux_out, r.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    n_vec++; n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  // Directed scenarios followed by randomized traffic.
  initial begin : stim
    int st;
    logic [31:0] ins, pc;
    logic [6:0] op;
    logic [2:0] lf;
    rst = 1'b0;
    dx_inst = '0; dx_pc = '0; dx_ALU_out = '0; dx_rf_out_B_forwarded = '0;
    cur = '{32'd0, 32'h0000_2000, 32'd0, 32'd0};
    repeat (2) @(negedge clk);
    chk("reset_mw_pc", mw_pc, 32'h0000_2000);
    chk("reset_mw_inst", mw_inst, 32'd0);
    chk("reset_mw_ALU_out", mw_ALU_out, 32'd0);
    chk("reset_stall", 32'(mw_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // ADDI x5 with result 7, then forwarding to a consumer of x5
    issue(mk(OP_IMM, 3'd0, 5'd5, 5'd1, 5'd0), 32'h100, 32'd7, 32'd0, st);
    dx_inst = mk(OP, 3'd0, 5'd6, 5'd5, 5'd9); #1;
    chk("addi_regwe", 32'(rf_regwe), 32'd1);
    chk("addi_rd", 32'(rf_rd), 32'd5);
    chk("addi_data", rf_write_data, 32'd7);
    chk("addi_stall", 32'(mw_stall), 32'd0);
    chk("addi_haz_ra", 32'(hazard_mw_dx_ra), 32'd1);
    chk("addi_haz_rb", 32'(hazard_mw_dx_rb), 32'd0);
    dx_inst = mk(OP, 3'd0, 5'd6, 5'd9, 5'd5); #1;
    chk("addi_haz_rb2", 32'(hazard_mw_dx_rb), 32'd1);
    issue(mk(OP, 3'd0, 5'd6, 5'd9, 5'd5), 32'h104, 32'h55, 32'd0, st);
    chk("addi_stalls", 32'(st), 32'd0);

    // LB at 0x103: one stall cycle, aligned address, sign-extended byte 3
    force_en = 1'b1; force_data = 32'h80FF_FF01;
    issue(mk(LOAD, 3'd0, 5'd7, 5'd2, 5'd0), 32'h108, 32'h103, 32'd0, st);
    #1;
    chk("lb_addr", dmem_req_addr, 32'h100);
    chk("lb_accept_stall", 32'(mw_stall), 32'd1);
    issue(mk(OP_IMM, 3'd0, 5'd0, 5'd0, 5'd0), 32'h10C, 32'd0, 32'd0, st);
    chk("lb_stalls", 32'(st), 32'd1);

    // LHU at 0x2 with ready held low for 3 cycles
    force_data = 32'hBEEF_1234; ready_hold = 3;
    issue(mk(LOAD, 3'd5, 5'd8, 5'd3, 5'd0), 32'h110, 32'h2, 32'd0, st);
    issue(mk(OP_IMM, 3'd0, 5'd0, 5'd0, 5'd0), 32'h114, 32'd0, 32'd0, st);
    chk("lhu_stalls", 32'(st), 32'd4);
    ready_hold = 0; force_en = 1'b0;

    // SB at 0x41
    issue(mk(STORE, 3'd0, 5'd3, 5'd1, 5'd2), 32'h118, 32'h41, 32'h1234_56AB, st);
    #1;
    chk("sb_valid", 32'(dmem_req_valid), 32'd1);
    chk("sb_we", 32'(dmem_req_we), 32'd1);
    chk("sb_wmask", 32'(dmem_req_wmask), 32'h2);
    chk("sb_wdata", dmem_req_wdata, 32'hABAB_ABAB);
    chk("sb_regwe", 32'(rf_regwe), 32'd0);
    issue(mk(OP_IMM, 3'd0, 5'd0, 5'd0, 5'd0), 32'h11C, 32'd0, 32'd0, st);
    chk("sb_stalls", 32'(st), 32'd0);

    // JAL link value wraps at 2^32
    issue(mk(JAL, 3'd0, 5'd1, 5'd0, 5'd0), 32'hFFFF_FFFC, 32'h1234, 32'd0, st);
    #1;
    chk("jal_wrap", rf_write_data, 32'd0);
    chk("jal_regwe", 32'(rf_regwe), 32'd1);

    // rd = x0 never writes or forwards
    issue(mk(OP_IMM, 3'd0, 5'd0, 5'd0, 5'd0), 32'h120, 32'h99, 32'd0, st);
    dx_inst = mk(OP, 3'd0, 5'd1, 5'd0, 5'd0); #1;
    chk("x0_regwe", 32'(rf_regwe), 32'd0);
    chk("x0_haz_ra", 32'(hazard_mw_dx_ra), 32'd0);
    chk("x0_haz_rb", 32'(hazard_mw_dx_rb), 32'd0);

    // Reset while waiting for a load response; the late response must be ignored
    resp_lat = 5;
    issue(mk(LOAD, 3'd2, 5'd9, 5'd1, 5'd0), 32'h200, 32'h300, 32'd0, st);
    @(negedge clk);
    chk("wr_accept", 32'(dmem_req_valid && dmem_req_ready), 32'd1);
    @(posedge clk); #1;
    chk("wr_wait_stall", 32'(mw_stall), 32'd1);
    rst = 1'b0;
    #1;
    chk("wr_rst_valid", 32'(dmem_req_valid), 32'd0);
    chk("wr_rst_stall", 32'(mw_stall), 32'd0);
    chk("wr_rst_pc", mw_pc, 32'h0000_2000);
    cur = '{32'd0, 32'h0000_2000, 32'd0, 32'd0};
    exp_mem.delete();
    exp_wb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    resp_lat = 0;
    for (int i = 0; i < 8; i++)
      issue(mk(OP_IMM, 3'd0, 5'd0, 5'd0, 5'd0), 32'h300 + 32'(4 * i), 32'd0, 32'd0, st);

    // Randomized traffic with random ready, latency and stray responses
    rnd_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    op = LOAD;
        2, 3:    op = STORE;
        4:       op = OP;
        5:       op = OP_IMM;
        6:       op = LUI;
        7:       op = AUIPC;
        8:       op = ($urandom_range(0, 1) == 1) ? JAL : JALR;
        default: op = 7'($urandom);
      endcase
      ins = $urandom;
      ins[6:0] = op;
      if (op == LOAD) begin
        lf = 3'($urandom_range(0, 4));
        if (lf >= 3'd3) lf = lf + 3'd1;
        ins[14:12] = lf;
      end
      if ($urandom_range(0, 3) == 0) ins[19:15] = cur.inst[11:7];
      if ($urandom_range(0, 3) == 0) ins[24:20] = cur.inst[11:7];
      if ($urandom_range(0, 7) == 0) ins[11:7] = '0;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      issue(ins, pc, $urandom, $urandom, st);
    end

    rnd_mode = 1'b0;
    for (int i = 0; i < 3; i++)
      issue(mk(OP_IMM, 3'd0, 5'd0, 5'd0, 5'd0), 32'h400, 32'd0, 32'd0, st);
    chk("mem_queue_drained", 32'(exp_mem.size()), 32'd0);
    chk("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
    summary();
    $finish;
  end

endmodule
